// File: rtl/regfile_scoreboard.sv
// 32x32 register file with a per-register busy scoreboard.
// Registered operand reads with writeback bypass and a pre-issue busy view.
module regfile_scoreboard (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    input  logic        rd_en,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    output logic        ready_A,
    output logic        ready_B,
    output logic        rd_valid
);

    logic [31:0] regs [32];
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    logic        wr_hit;
    logic        iss_hit;

    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        rdy_a;
    logic        rdy_b;

    logic [31:0] data_a_p1;
    logic [31:0] data_b_p1;
    logic        rdy_a_p1;
    logic        rdy_b_p1;
    logic        vld_p1;

    assign wr_hit  = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    assign iss_hit = issue_valid && (issue_reg != 5'd0);

    // Issue is applied after writeback so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit)
            busy_nxt[ctrl_writeReg] = 1'b0;
        if (iss_hit)
            busy_nxt[issue_reg] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Reads see the writeback data but the busy state from before any same-cycle issue.
    always_comb begin
        rdata_a = regs[ctrl_readRegA];
        rdy_a   = ~busy[ctrl_readRegA];
        if (wr_hit && (ctrl_writeReg == ctrl_readRegA)) begin
            rdata_a = data_writeReg;
            rdy_a   = ~(iss_hit && (issue_reg == ctrl_readRegA));
        end
        if (ctrl_readRegA == 5'd0) begin
            rdata_a = 32'd0;
            rdy_a   = 1'b1;
        end
    end

    always_comb begin
        rdata_b = regs[ctrl_readRegB];
        rdy_b   = ~busy[ctrl_readRegB];
        if (wr_hit && (ctrl_writeReg == ctrl_readRegB)) begin
            rdata_b = data_writeReg;
            rdy_b   = ~(iss_hit && (issue_reg == ctrl_readRegB));
        end
        if (ctrl_readRegB == 5'd0) begin
            rdata_b = 32'd0;
            rdy_b   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
            busy <= 32'd0;
        end else begin
            if (wr_hit)
                regs[ctrl_writeReg] <= data_writeReg;
            busy <= busy_nxt;
        end
    end

    // Stage p1: registered operand outputs, held while no read is requested.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_a_p1 <= 32'd0;
            data_b_p1 <= 32'd0;
            rdy_a_p1  <= 1'b1;
            rdy_b_p1  <= 1'b1;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                data_a_p1 <= rdata_a;
                data_b_p1 <= rdata_b;
                rdy_a_p1  <= rdy_a;
                rdy_b_p1  <= rdy_b;
            end
        end
    end

    assign data_readRegA = data_a_p1;
    assign data_readRegB = data_b_p1;
    assign ready_A       = rdy_a_p1;
    assign ready_B       = rdy_b_p1;
    assign rd_valid      = vld_p1;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expected read results queue up when a
// read is driven and are checked when the registered result appears.
module tb_regfile_scoreboard;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        rd_en;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ready_A;
    logic        ready_B;
    logic        rd_valid;

    typedef struct {
        logic [31:0] a;
        logic        ra;
        logic [31:0] b;
        logic        rb;
    } exp_t;

    exp_t q[$];
    exp_t hold;
    int   tests;
    int   fails;

    regfile_scoreboard dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .rd_en            (rd_en),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ready_A          (ready_A),
        .ready_B          (ready_B),
        .rd_valid         (rd_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic vld_exp);
        chk({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, vld_exp});
        chk({tag, ".dataA"}, data_readRegA, hold.a);
        chk({tag, ".readyA"}, {31'd0, ready_A}, {31'd0, hold.ra});
        chk({tag, ".dataB"}, data_readRegB, hold.b);
        chk({tag, ".readyB"}, {31'd0, ready_B}, {31'd0, hold.rb});
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic re, input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        issue_valid      = iv;
        issue_reg        = ir;
        rd_en            = re;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
    endtask

    // One clock of stimulus; when re=1 the expected operands are queued for the next edge.
    task automatic step(input string tag,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ir,
                        input logic re, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic era,
                        input logic [31:0] eb, input logic erb);
        exp_t e;
        @(negedge clock);
        drive(we, wr, wd, iv, ir, re, ra, rb);
        if (re) begin
            e.a = ea; e.ra = era; e.b = eb; e.rb = erb;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (re) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s.queue observed=empty expected=entry", tag);
            end else begin
                hold = q.pop_front();
            end
        end
        chk_outputs(tag, re);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        hold.a = 32'd0; hold.ra = 1'b1; hold.b = 32'd0; hold.rb = 1'b1;

        // Reset with active inputs that must have no effect.
        reset = 1'b0;
        drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6, 1'b1, 5'd5, 5'd6);
        @(posedge clock);
        #1;
        chk_outputs("reset0", 1'b0);
        @(posedge clock);
        #1;
        chk_outputs("reset1", 1'b0);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        reset = 1'b1;

        // Inputs during reset left no trace.
        step("post_reset", 0, 0, 0, 0, 0, 1, 5'd5, 5'd6, 32'd0, 1, 32'd0, 1);

        // Basic write then read.
        step("wr5",   1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd5",   0, 0, 0, 0, 0, 1, 5'd5, 5'd0, 32'hDEADBEEF, 1, 32'd0, 1);

        // Same-cycle write/read bypass.
        step("byp7",  1, 5'd7, 32'h12345678, 0, 0, 1, 5'd7, 5'd0, 32'h12345678, 1, 32'd0, 1);
        step("idle",  0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 0, 0, 0, 0);

        // Issue marks busy; writeback clears it.
        step("iss3",  0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        step("rd3",   0, 0, 0, 0, 0, 1, 5'd3, 5'd7, 32'd0, 0, 32'h12345678, 1);
        step("wb3",   1, 5'd3, 32'hA5A5A5A5, 0, 0, 1, 5'd3, 5'd3, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1);

        // Read during issue sees pre-issue state.
        step("iss4rd", 0, 0, 0, 1, 5'd4, 1, 5'd4, 5'd3, 32'd0, 1, 32'hA5A5A5A5, 1);
        step("rd4",   0, 0, 0, 0, 0, 1, 5'd4, 5'd4, 32'd0, 0, 32'd0, 0);

        // Simultaneous issue and writeback stays busy.
        step("iswb9", 1, 5'd9, 32'h00000055, 1, 5'd9, 1, 5'd9, 5'd5, 32'h55, 0, 32'hDEADBEEF, 1);
        step("rd9",   0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 32'h55, 0, 32'h55, 0);

        // Register 0 ignores writes and issues.
        step("r0wi",  1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 5'd0, 32'd0, 1, 32'd0, 1);
        step("rd0",   0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 32'd0, 1, 32'd0, 1);

        // Write and issue to different indices in one cycle.
        step("wb4",   1, 5'd4, 32'h00000077, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd4b",  0, 0, 0, 0, 0, 1, 5'd4, 5'd9, 32'h77, 1, 32'h55, 0);
        step("mix",   1, 5'd9, 32'h00000099, 1, 5'd4, 1, 5'd9, 5'd4, 32'h99, 1, 32'h77, 1);
        step("rdmix", 0, 0, 0, 0, 0, 1, 5'd4, 5'd9, 32'h77, 0, 32'h99, 1);

        // Reset mid-operation discards the pending read.
        step("ld1",   1, 5'd1, 32'h00000001, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(1'b1, 5'd5, 32'h0BADBEEF, 1'b1, 5'd1, 1'b1, 5'd1, 5'd2);
        #2;
        reset = 1'b0;
        q.delete();
        hold.a = 32'd0; hold.ra = 1'b1; hold.b = 32'd0; hold.rb = 1'b1;
        #1;
        chk_outputs("midrst", 1'b0);
        @(posedge clock);
        #1;
        chk_outputs("midrst_edge", 1'b0);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        reset = 1'b1;
        step("rd12",  0, 0, 0, 0, 0, 1, 5'd1, 5'd2, 32'd0, 1, 32'd0, 1);
        step("rd53",  0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 32'd0, 1, 32'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters: none; fixed at 32 registers x 32 bits, 5-bit register indices.
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately, independent of clock.
REQ-004 ctrl_writeEnable  in  1  writeback strobe.
REQ-005 ctrl_writeReg  in  5  writeback destination index.
REQ-006 data_writeReg  in  32  writeback data.
REQ-007 issue_valid  in  1  instruction issued; marks destination busy.
REQ-008 issue_reg  in  5  destination index of issued instruction.
REQ-009 rd_en  in  1  operand read request.
REQ-010 ctrl_readRegA, ctrl_readRegB  in  5 each  source indices; these feed the 32:1 read-select muxes.
REQ-011 data_readRegA, data_readRegB  out  32 each  registered operand data.
REQ-012 ready_A, ready_B  out  1 each  operand valid (producer not outstanding).
REQ-013 rd_valid  out  1  outputs updated by a read accepted the previous cycle.

Function
REQ-014 Storage SHALL be 32 registers x 32 bits plus a 32-bit busy vector.
REQ-015 Register 0 SHALL always read 0x00000000 and never be busy; writes and issues to index 0 are ignored.
REQ-016 Writeback: ctrl_writeEnable=1 with index != 0 SHALL load data_writeReg and clear busy[index] at the edge.
REQ-017 Issue: issue_valid=1 with index != 0 SHALL set busy[index] at the edge.
REQ-018 Issue and writeback to the same index in the same cycle SHALL leave busy set; data is still written.
REQ-019 Read latency SHALL be one cycle: with rd_en=1 at edge N, data/ready outputs and rd_valid=1 are presented after edge N.
REQ-020 rd_en=0 at an edge SHALL drive rd_valid=0 and hold data_readRegA/B and ready_A/B unchanged.
REQ-021 Write-read bypass: a read of index R in the same cycle as a writeback to R (R != 0) SHALL return data_writeReg with ready=1, unless REQ-022 applies.
REQ-022 Issue-read ordering: a read in the same cycle as an issue to R SHALL see the pre-issue busy state; with simultaneous issue and writeback to R, the read SHALL return the written data with ready=0.
REQ-023 ready_X SHALL equal NOT busy[ctrl_readRegX] after applying REQ-021/022; index 0 always ready.
REQ-024 Ports A and B SHALL be independent; A == B SHALL return identical data and ready.
REQ-025 Reads, writes and issues SHALL all be accepted every cycle with no backpressure or stall.

Reset
REQ-026 While reset=0: all 32 registers = 0, busy = 0, data_readRegA/B = 0, ready_A/B = 1, rd_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard pending read results; the first edge after deassertion with rd_en=1 returns reset values.
REQ-028 Inputs during reset SHALL have no effect on state.

Verification
REQ-029 Reset, then write R5=0xDEADBEEF, next cycle rd_en A=5 -> one cycle later data_readRegA=0xDEADBEEF, ready_A=1, rd_valid=1.
REQ-030 Same cycle: write R7=0x12345678, rd_en A=7, B=0 -> next cycle A=0x12345678 (bypass), ready_A=1, B=0x00000000, ready_B=1.
REQ-031 Issue R3; next cycle read A=3 -> ready_A=0; then write R3=0xA5A5A5A5 while reading A=3 -> ready_A=1, data 0xA5A5A5A5.
REQ-032 Issue R9 and write R9=0x55 in the same cycle, reading A=9 -> data 0x55, ready_A=0; a later read without writeback -> ready_A=0.
REQ-033 Write R0=0xFFFFFFFF and issue R0, then read A=0, B=0 -> both 0x00000000, ready=1.
REQ-034 Load R1=0x1 and issue R2, assert reset mid-cycle for 1 cycle, then read A=1, B=2 -> A=0, B=0, both ready=1, rd_valid=0 during reset.
